// File: rtl/spi_adc_pkg.sv
// Shared FSM state encoding and default parameter values for the SPI ADC scanner.
package spi_adc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StSetup = 3'd1;
  localparam state_t StShift = 3'd2;
  localparam state_t StHold  = 3'd3;
  localparam state_t StGap   = 3'd4;

  localparam int unsigned DefDataW     = 12;
  localparam int unsigned DefNumCh     = 4;
  localparam int unsigned DefClkDiv    = 4;
  localparam int unsigned DefCmdW      = 4;
  localparam int unsigned DefFrameBits = 16;
  localparam int unsigned DefCsGap     = 2;

endpackage

// File: rtl/spi_sck_gen.sv
// CLK_DIV phase counter: end-of-phase tick, SCK rise/fall strobes and the registered SCK.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count,
  input  logic toggle,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sck
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            sck_q;

  assign tick = count && (cnt_q == CntW'(CLK_DIV - 1));
  // Strobes fire on the clk edge at which sck_q changes.
  assign rise = toggle && tick && !sck_q;
  assign fall = toggle && tick && sck_q;
  assign sck  = sck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      if (!count || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (!toggle) begin
        sck_q <= 1'b0;
      end else if (tick) begin
        sck_q <= !sck_q;
      end
    end
  end

endmodule

// File: rtl/spi_adc_scanner.sv
// Round-robin SPI ADC channel scanner with valid/ready result port and sticky overrun.
// Define SPI_ADC_AVG_EN to average 4 consecutive frames per channel into one result.
import spi_adc_pkg::*;

module spi_adc_scanner #(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned CLK_DIV    = DefClkDiv,
  parameter int unsigned CMD_W      = DefCmdW,
  parameter int unsigned FRAME_BITS = DefFrameBits,
  parameter int unsigned CS_GAP     = DefCsGap
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic              cs_n,
  output logic [DATA_W-1:0] m_data,
  output logic [2:0]        m_ch,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);
  localparam int unsigned GapW   = $clog2(CS_GAP + 1);
  localparam int unsigned CmdChW = CMD_W - 1;

  state_t              state_q, state_d;
  logic [BitW-1:0]     bit_cnt_q;
  logic [GapW-1:0]     gap_cnt_q;
  logic [2:0]          ch_q;
  logic [CMD_W-1:0]    cmd_sr_q;
  logic                mosi_q;
  logic [DATA_W-1:0]   rx_q;
  logic [DATA_W-1:0]   m_data_q;
  logic [2:0]          m_ch_q;
  logic                m_valid_q;
  logic                overrun_q;
  logic                cs_n_q;

  logic                tick, rise, fall;
  logic                last_bit, gap_last, start, frame_done;
  logic                result_go, grp_busy;
  logic [DATA_W-1:0]   result_data;
  logic [CMD_W-1:0]    cmd_word;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .count  ((state_q == StSetup) || (state_q == StShift) || (state_q == StHold)),
    .toggle (state_q == StShift),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sck    (sck)
  );

  assign last_bit   = (bit_cnt_q == BitW'(FRAME_BITS - 1));
  assign gap_last   = (gap_cnt_q == GapW'(CS_GAP - 1));
  assign start      = (state_d == StSetup) && (state_q != StSetup);
  assign frame_done = (state_q == StHold) && tick;
  assign cmd_word   = {1'b1, CmdChW'(ch_q)};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en) state_d = StSetup;
      StSetup: if (tick) state_d = StShift;
      StShift: if (fall && last_bit) state_d = StHold;
      StHold:  if (tick) state_d = StGap;
      StGap:   if (gap_last) state_d = (en || grp_busy) ? StSetup : StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef SPI_ADC_AVG_EN
  localparam int unsigned AccW = DATA_W + 2;

  logic [1:0]      grp_q;
  logic [AccW-1:0] acc_q;
  logic [AccW-1:0] acc_sum;

  assign acc_sum     = acc_q + AccW'(rx_q);
  assign result_go   = frame_done && (grp_q == 2'd3);
  assign result_data = acc_sum[AccW-1:2];
  // A partially collected group keeps the scan running even after en drops.
  assign grp_busy    = (grp_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q <= 2'd0;
      acc_q <= '0;
    end else if (frame_done) begin
      grp_q <= grp_q + 2'd1;
      acc_q <= result_go ? '0 : acc_sum;
    end
  end
`else
  assign result_go   = frame_done;
  assign result_data = rx_q;
  assign grp_busy    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ch_q      <= 3'd0;
      cmd_sr_q  <= '0;
      mosi_q    <= 1'b0;
      rx_q      <= '0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cs_n_q  <= !((state_d == StSetup) || (state_d == StShift) || (state_d == StHold));

      if (start) begin
        bit_cnt_q <= '0;
      end else if (fall) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (state_q == StGap) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end else begin
        gap_cnt_q <= '0;
      end

      // Command goes out MSB first; zeros fill once the shifter drains.
      if (start) begin
        mosi_q   <= cmd_word[CMD_W-1];
        cmd_sr_q <= {cmd_word[CMD_W-2:0], 1'b0};
      end else if (fall) begin
        mosi_q   <= cmd_sr_q[CMD_W-1];
        cmd_sr_q <= {cmd_sr_q[CMD_W-2:0], 1'b0};
      end

      if (rise) begin
        rx_q <= {rx_q[DATA_W-2:0], miso};
      end

      if (result_go) begin
        ch_q <= (ch_q == 3'(NUM_CH - 1)) ? 3'd0 : ch_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q  <= '0;
      m_ch_q    <= 3'd0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (result_go) begin
      m_data_q  <= result_data;
      m_ch_q    <= ch_q;
      m_valid_q <= 1'b1;
      if (m_valid_q && !m_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign m_data  = m_data_q;
  assign m_ch    = m_ch_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Self-checking bench: behavioural ADC slave plus result scoreboard for spi_adc_scanner.
module tb_spi_adc_scanner;

  localparam int DW     = 12;
  localparam int NCH    = 4;
  localparam int CD     = 4;
  localparam int CW     = 4;
  localparam int FB     = 16;
  localparam int GAP    = 2;
  localparam int PERIOD = (2 * FB + 2) * CD + GAP;
`ifdef SPI_ADC_AVG_EN
  localparam int RES_FR = 4;
`else
  localparam int RES_FR = 1;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          en      = 1'b0;
  logic          miso    = 1'b0;
  logic          m_ready = 1'b0;
  logic          mosi, sck, cs_n, m_valid, overrun, busy;
  logic [DW-1:0] m_data;
  logic [2:0]    m_ch;

  spi_adc_scanner dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .miso    (miso),
    .mosi    (mosi),
    .sck     (sck),
    .cs_n    (cs_n),
    .m_data  (m_data),
    .m_ch    (m_ch),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .overrun (overrun),
    .busy    (busy)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int data;
    int ch;
  } res_t;

  res_t          rq[$];
  int            smp_q[$];
  int            exp_ch = 0, grp = 0, acc = 0;
  bit            exp_ovr = 1'b0;
  int            frames_done = 0, nrise = 0, bit_idx = 0, sample = 0;
  int            cyc = 0, prev_fall = -1;
  bit            active = 1'b0, chk_period = 1'b0;
  bit            got_first = 1'b0;
  int            first_data = 0, first_ch = 0;
  logic [FB-1:0] word = '0, cap = '0;

  task automatic emit(input int d);
    res_t r;
    // An unaccepted result still queued means the new one overwrites it.
    if (rq.size() != 0) begin
      exp_ovr = 1'b1;
      void'(rq.pop_front());
    end
    r.data = d;
    r.ch   = exp_ch;
    rq.push_back(r);
    exp_ch = (exp_ch + 1) % NCH;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC slave: frame word = random upper bits, chosen sample in the low DW bits.
  initial forever begin
    @(negedge cs_n);
    if (rst_n) begin
      if (chk_period && prev_fall >= 0) check("frame_period", cyc - prev_fall, PERIOD);
      prev_fall = cyc;
      if (smp_q.size() != 0) sample = smp_q.pop_front();
      else sample = int'($urandom_range(0, (1 << DW) - 1));
      word = FB'($urandom);
      word[DW-1:0] = sample[DW-1:0];
      bit_idx = 0;
      nrise = 0;
      cap = '0;
      active = 1'b1;
      miso = word[FB-1];
    end
  end

  initial forever begin
    @(posedge sck);
    if (active) begin
      cap = {cap[FB-2:0], mosi};
      nrise++;
    end
  end

  initial forever begin
    @(negedge sck);
    if (active && rst_n) begin
      bit_idx++;
      miso = (bit_idx < FB) ? word[FB-1-bit_idx] : 1'b0;
    end
  end

  initial forever begin
    @(posedge cs_n);
    if (rst_n && active) begin
      active = 1'b0;
      frames_done++;
      check("sck_pulses", nrise, FB);
      check("mosi_cmd", cap, ((1 << (CW - 1)) | exp_ch) << (FB - CW));
`ifdef SPI_ADC_AVG_EN
      acc += sample;
      grp++;
      if (grp == 4) begin
        emit(acc / 4);
        acc = 0;
        grp = 0;
      end
`else
      emit(sample);
`endif
    end else begin
      active = 1'b0;
    end
  end

  initial forever begin
    @(negedge rst_n);
    rq.delete();
    exp_ch = 0;
    grp = 0;
    acc = 0;
    exp_ovr = 1'b0;
    prev_fall = -1;
    active = 1'b0;
  end

  // Result port monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("m_valid", m_valid, 32'(rq.size() != 0));
      check("overrun", overrun, exp_ovr);
      if (m_valid && rq.size() != 0) begin
        check("m_data", m_data, rq[0].data);
        check("m_ch", m_ch, rq[0].ch);
        if (m_ready) begin
          if (!got_first) begin
            got_first  = 1'b1;
            first_data = m_data;
            first_ch   = m_ch;
          end
          void'(rq.pop_front());
        end
      end
    end
  end

  task automatic wait_frames(input int n);
    int target;
    target = frames_done + n;
    for (int i = 0; i < n * PERIOD + 400 && frames_done < target; i++) @(posedge clk);
    check("wait_frames", frames_done, target);
  endtask

  initial begin
    int f0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_ch", m_ch, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed first sample(s), continuous scan, period measured frame to frame.
`ifdef SPI_ADC_AVG_EN
    smp_q.push_back(100);
    smp_q.push_back(101);
    smp_q.push_back(102);
    smp_q.push_back(103);
`else
    smp_q.push_back('hA5C);
`endif
    m_ready = 1'b1;
    chk_period = 1'b1;
    en = 1'b1;
    wait_frames(5 * RES_FR);
    chk_period = 1'b0;
    check("first_ch", first_ch, 0);
`ifdef SPI_ADC_AVG_EN
    check("first_data", first_data, 101);
`else
    check("first_data", first_data, 'hA5C);
`endif

    // Consumer stalls over two results.
    @(posedge clk);
    #1 m_ready = 1'b0;
    wait_frames(2 * RES_FR);
    @(negedge clk);
    check("overrun_set", overrun, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;

    // Random back-pressure.
    for (int i = 0; i < 4 * PERIOD * RES_FR; i++) begin
      @(posedge clk);
      #1 m_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1 m_ready = 1'b1;

    // Reset during the 7th SCK pulse aborts the frame.
    for (int i = 0; i < 2 * PERIOD && !(active && nrise == 7); i++) @(posedge clk);
    check("sck7_reached", nrise, 7);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_sck", sck, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_overrun", overrun, 0);
    check("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frames(RES_FR);

    // Drop en mid-shift: the frame (or group) completes, then the scanner idles.
    for (int i = 0; i < 2 * PERIOD && !(active && nrise >= 3); i++) @(posedge clk);
    check("shift_reached", 32'(nrise >= 3), 1);
    f0 = frames_done;
    #1 en = 1'b0;
    for (int i = 0; i < 2 * PERIOD * RES_FR && busy !== 1'b0; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_cs_n", cs_n, 1);
    check("stop_drained", rq.size(), 0);
`ifdef SPI_ADC_AVG_EN
    check("stop_group_done", grp, 0);
`else
    check("stop_frames", frames_done, f0 + 1);
`endif
    repeat (50) @(posedge clk);
    #1;
    check("idle_cs_n", cs_n, 1);
    check("idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
